// File: rtl/tokenflow_pkg.sv
// tokenflow_pkg: shared definitions for the tokenflow sequence generator.
//   - mode encodings (MODE_PRONIC .. MODE_LINEAR)
//   - FSM state encoding (the 4-phase states exist only with TOKENFLOW_FOUR_PHASE_EN)
//   - per-mode difference-engine init table (d0, dd0); v always starts at 0
package tokenflow_pkg;

   localparam logic [1:0] MODE_PRONIC     = 2'd0;
   localparam logic [1:0] MODE_SQUARE     = 2'd1;
   localparam logic [1:0] MODE_TRIANGULAR = 2'd2;
   localparam logic [1:0] MODE_LINEAR     = 2'd3;

`ifdef TOKENFLOW_FOUR_PHASE_EN
   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StPresent = 3'd1,
      StWaitHi  = 3'd2,
      StWaitLo  = 3'd3,
      StDone    = 3'd4
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StPresent = 3'd1,
      StWait    = 3'd2,
      StDone    = 3'd3
   } state_e;
`endif

   typedef struct packed {
      logic [1:0] d0;   // first difference
      logic [1:0] dd0;  // constant second difference
   } init_t;

   function automatic init_t mode_init(input logic [1:0] mode);
      init_t r;
      case (mode)
         MODE_PRONIC:     r = '{d0: 2'd2, dd0: 2'd2};
         MODE_SQUARE:     r = '{d0: 2'd1, dd0: 2'd2};
         MODE_TRIANGULAR: r = '{d0: 2'd1, dd0: 2'd1};
         default:         r = '{d0: 2'd1, dd0: 2'd0};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tokenflow_seqgen_if.sv
// tokenflow_seqgen_if: bundled-data token channel.
//   req  : request (2-phase transition or 4-phase level, producer driven)
//   data : token payload, stable before req moves
//   ack  : acknowledge from the consumer, not synchronous to the producer clock
interface tokenflow_seqgen_if #(
   parameter int unsigned W = 16
) ();
   logic         req;
   logic [W-1:0] data;
   logic         ack;

   modport master (output req, output data, input ack);
   modport slave  (input req, input data, output ack);
endinterface

// File: rtl/tokenflow_sync.sv
// tokenflow_sync: Stages-deep flop chain bringing an asynchronous level into clk.
//   clk     : clock
//   reset   : synchronous, active-high; clears the chain to 0
//   async_i : asynchronous input
//   sync_o  : synchronised output (Stages cycles of latency); Stages must be >= 2
module tokenflow_sync #(
   parameter int unsigned Stages = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic sync_o
);

   logic [Stages-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[Stages-2:0], async_i};
      end
   end

   assign sync_o = sync_q[Stages-1];

endmodule

// File: rtl/tokenflow_seqgen.sv
// tokenflow_seqgen: emits a polynomial sequence (pronic, square, triangular, linear) as
// bundled-data tokens. Values come from a second-order difference engine (adders only).
//   clk    : clock
//   reset  : synchronous, active-high
//   enable : high starts/continues a run; low stops at the next token boundary
//   mode   : sequence select, sampled only when a run starts
//   ch     : token channel (master side): req/data out, ack in (asynchronous)
//   busy   : high while a token is being presented/acknowledged
//   done   : high once LIMIT tokens were sent, until enable drops
// Parameters: W data width (mod 2^W arithmetic), LIMIT tokens per run (0 = unbounded),
// SYNC_STAGES ack synchroniser depth.
// Build option: TOKENFLOW_FOUR_PHASE_EN selects 4-phase return-to-zero signalling;
// the default is 2-phase transition signalling.
module tokenflow_seqgen
   import tokenflow_pkg::*;
#(
   parameter int unsigned W           = 16,
   parameter int unsigned LIMIT       = 0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [1:0]         mode,
   tokenflow_seqgen_if.master ch,
   output logic               busy,
   output logic               done
);

   localparam int unsigned CntW = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);

   state_e       state_q, state_d, exit_st;
   logic         req_q, req_d;
   logic [W-1:0] v_q, v_d, d_q, d_d;
   logic [1:0]   dd_q, dd_d;
   logic         ack_s, load, step, last;
   init_t        init;

   tokenflow_sync #(
      .Stages (SYNC_STAGES)
   ) u_ack_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (ch.ack),
      .sync_o  (ack_s)
   );

   // Token counter only exists for bounded runs.
   if (LIMIT != 0) begin : g_cnt
      logic [CntW-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (load) begin
            cnt_d = '0;
         end else if (step) begin
            cnt_d = cnt_q + CntW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

`ifdef TOKENFLOW_FOUR_PHASE_EN
      // Exit decision happens in WAIT_LO, after the count already advanced.
      assign last = (cnt_q == CntW'(LIMIT));
`else
      // Exit decision coincides with the step, so look one token ahead.
      assign last = ((cnt_q + CntW'(1)) == CntW'(LIMIT));
`endif
   end else begin : g_no_cnt
      assign last = 1'b0;
   end

   // Where to go once a token has been fully acknowledged.
   assign exit_st = last ? StDone : (enable ? StPresent : StIdle);

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         v_q     <= '0;
         d_q     <= '0;
         dd_q    <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         v_q     <= v_d;
         d_q     <= d_d;
         dd_q    <= dd_d;
      end
   end

   // Next state, req and engine strobes.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      load    = 1'b0;
      step    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable) begin
               load    = 1'b1;
               state_d = StPresent;
            end
         end
`ifdef TOKENFLOW_FOUR_PHASE_EN
         StPresent: begin
            req_d   = 1'b1;
            state_d = StWaitHi;
         end
         StWaitHi: begin
            if (ack_s) begin
               req_d   = 1'b0;
               step    = 1'b1;
               state_d = StWaitLo;
            end
         end
         StWaitLo: begin
            if (!ack_s) begin
               state_d = exit_st;
            end
         end
`else
         StPresent: begin
            // data was loaded/stepped at least one cycle earlier
            req_d   = ~req_q;
            state_d = StWait;
         end
         StWait: begin
            if (ack_s == req_q) begin
               step    = 1'b1;
               state_d = exit_st;
            end
         end
`endif
         StDone: begin
            if (!enable) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Difference engine: v += d, d += dd, all modulo 2^W.
   always_comb begin
      init = mode_init(mode);
      v_d  = v_q;
      d_d  = d_q;
      dd_d = dd_q;
      if (load) begin
         v_d  = '0;
         d_d  = W'(init.d0);
         dd_d = init.dd0;
      end else if (step) begin
         v_d = v_q + d_q;
         d_d = d_q + W'(dd_q);
      end
   end

   // Status outputs.
   always_comb begin
`ifdef TOKENFLOW_FOUR_PHASE_EN
      busy = (state_q == StPresent) || (state_q == StWaitHi) || (state_q == StWaitLo);
`else
      busy = (state_q == StPresent) || (state_q == StWait);
`endif
      done = (state_q == StDone);
   end

   assign ch.req  = req_q;
   assign ch.data = v_q;

endmodule

// File: tb/tb_tokenflow_seqgen.sv
// tb_tokenflow_seqgen: self-checking bench for tokenflow_seqgen.
// Three instances: A (W=16, unbounded, delayed consumer), W (W=8, wrap),
// L (W=16, LIMIT=5). Expected tokens go into per-instance queues when a run is
// started and are popped/compared by monitors at each token event.
// Honours TOKENFLOW_FOUR_PHASE_EN for the 4-phase build.
module tb_tokenflow_seqgen;

`ifdef TOKENFLOW_FOUR_PHASE_EN
   localparam bit FourPh = 1'b1;
`else
   localparam bit FourPh = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  mode;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [21];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en_a, en_w, en_l;
   logic [1:0] mode_a, mode_w, mode_l;
   logic       busy_a, done_a, busy_w, done_w, busy_l, done_l;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned ev_a     = 0;
   int unsigned n_l      = 0;
   int unsigned ack_dly  = 0;
   logic        prev_a, prev_w, prev_l;

   logic [15:0] q_a [$];
   logic [7:0]  q_w [$];
   logic [15:0] q_l [$];

   tokenflow_seqgen_if #(.W(16)) if_a ();
   tokenflow_seqgen_if #(.W(8))  if_w ();
   tokenflow_seqgen_if #(.W(16)) if_l ();

   tokenflow_seqgen #(.W(16), .LIMIT(0), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .reset(rst), .enable(en_a), .mode(mode_a), .ch(if_a),
      .busy(busy_a), .done(done_a)
   );
   tokenflow_seqgen #(.W(8), .LIMIT(0), .SYNC_STAGES(2)) dut_w (
      .clk(clk), .reset(rst), .enable(en_w), .mode(mode_w), .ch(if_w),
      .busy(busy_w), .done(done_w)
   );
   tokenflow_seqgen #(.W(16), .LIMIT(5), .SYNC_STAGES(2)) dut_l (
      .clk(clk), .reset(rst), .enable(en_l), .mode(mode_l), .ch(if_l),
      .busy(busy_l), .done(done_l)
   );

   assign if_w.ack = if_w.req;
   assign if_l.ack = if_l.req;

   // Consumer for A: ack follows req after ack_dly extra cycles; reset with the DUT.
   initial begin : cons_a
      int unsigned cnt;
      cnt = 0;
      if_a.ack <= 1'b0;
      forever begin
         @(posedge clk);
         if (rst) begin
            if_a.ack <= 1'b0;
            cnt = 0;
         end else if (if_a.ack != if_a.req) begin
            if (cnt >= ack_dly) begin
               if_a.ack <= if_a.req;
               cnt = 0;
            end else begin
               cnt++;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic is_ev(input logic req, input logic prev, input logic busy);
      return busy && (FourPh ? (req && !prev) : (req != prev));
   endfunction

   initial begin : mon_a
      prev_a = 1'b0;
      forever begin
         @(negedge clk);
         if (is_ev(if_a.req, prev_a, busy_a)) begin
            ev_a++;
            if (q_a.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL a_extra_token: got data=%0d, expected no token", if_a.data);
            end else begin
               check("a_token", 32'(if_a.data), 32'(q_a.pop_front()));
            end
         end
         prev_a = if_a.req;
      end
   end

   initial begin : mon_w
      prev_w = 1'b0;
      forever begin
         @(negedge clk);
         if (is_ev(if_w.req, prev_w, busy_w)) begin
            if (q_w.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL w_extra_token: got data=%0d, expected no token", if_w.data);
            end else begin
               check("w_token", 32'(if_w.data), 32'(q_w.pop_front()));
            end
         end
         prev_w = if_w.req;
      end
   end

   initial begin : mon_l
      prev_l = 1'b0;
      forever begin
         @(negedge clk);
         if (is_ev(if_l.req, prev_l, busy_l)) begin
            if (q_l.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL l_extra_token: got data=%0d, expected no token", if_l.data);
            end else begin
               check("l_token", 32'(if_l.data), 32'(q_l.pop_front()));
            end
         end
         prev_l = if_l.req;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1, "timeout");
   end

   task automatic wait_empty_a(input int unsigned bound);
      for (int i = 0; i < int'(bound) && q_a.size() != 0; i++) @(negedge clk);
      check("a_tokens_seen", 32'(q_a.size()), 32'd0);
   endtask

   task automatic wait_idle_a(input int unsigned bound);
      for (int i = 0; i < int'(bound) && busy_a; i++) @(negedge clk);
      check("a_idle", 32'(busy_a), 32'd0);
   endtask

   // Runs one table group on A; mode is wiggled mid-run and must be ignored.
   task automatic run_mode(input logic [1:0] m);
      mode_a = m;
      foreach (vecs[i]) if (vecs[i].mode == m) q_a.push_back(vecs[i].exp);
      en_a = 1'b1;
      repeat (6) @(negedge clk);
      mode_a = m ^ 2'b11;
      wait_empty_a(400);
      en_a = 1'b0;
      wait_idle_a(200);
   endtask

   task automatic run_limit();
      logic r;
      bit   held;
      mode_l = 2'd1;
      for (int k = 0; k < 5; k++) q_l.push_back(16'(k * k));
      n_l += 5;
      en_l = 1'b1;
      for (int i = 0; i < 300 && !done_l; i++) @(negedge clk);
      check("l_done", 32'(done_l), 32'd1);
      check("l_busy", 32'(busy_l), 32'd0);
      check("l_req_level", 32'(if_l.req), FourPh ? 32'd0 : 32'(n_l % 2));
      r    = if_l.req;
      held = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (if_l.req != r || !done_l) held = 1'b0;
      end
      check("l_req_stable", 32'(held), 32'd1);
      check("l_all_tokens", 32'(q_l.size()), 32'd0);
   endtask

   initial begin : main
      logic        r;
      logic [15:0] d;
      bit          held;

      vecs[0]  = '{2'd0, 16'd0};  vecs[1]  = '{2'd0, 16'd2};  vecs[2]  = '{2'd0, 16'd6};
      vecs[3]  = '{2'd0, 16'd12}; vecs[4]  = '{2'd0, 16'd20}; vecs[5]  = '{2'd0, 16'd30};
      vecs[6]  = '{2'd0, 16'd42};
      vecs[7]  = '{2'd1, 16'd0};  vecs[8]  = '{2'd1, 16'd1};  vecs[9]  = '{2'd1, 16'd4};
      vecs[10] = '{2'd1, 16'd9};  vecs[11] = '{2'd1, 16'd16};
      vecs[12] = '{2'd2, 16'd0};  vecs[13] = '{2'd2, 16'd1};  vecs[14] = '{2'd2, 16'd3};
      vecs[15] = '{2'd2, 16'd6};  vecs[16] = '{2'd2, 16'd10};
      vecs[17] = '{2'd3, 16'd0};  vecs[18] = '{2'd3, 16'd1};  vecs[19] = '{2'd3, 16'd2};
      vecs[20] = '{2'd3, 16'd3};

      rst = 1'b1;
      en_a = 1'b0; en_w = 1'b0; en_l = 1'b0;
      mode_a = 2'd0; mode_w = 2'd0; mode_l = 2'd0;
      repeat (3) @(negedge clk);
      check("rst_req", 32'(if_a.req), 32'd0);
      check("rst_data", 32'(if_a.data), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven streams on A.
      for (int m = 0; m < 4; m++) run_mode(2'(m));

      // Wrap on the 8-bit instance: token k is k*(k+1) mod 256.
      mode_w = 2'd0;
      for (int k = 0; k < 17; k++) q_w.push_back(8'((k * (k + 1)) % 256));
      en_w = 1'b1;
      for (int i = 0; i < 600 && q_w.size() != 0; i++) @(negedge clk);
      check("w_tokens_seen", 32'(q_w.size()), 32'd0);
      en_w = 1'b0;
      for (int i = 0; i < 100 && busy_w; i++) @(negedge clk);
      check("w_idle", 32'(busy_w), 32'd0);

      // Limit: two runs of 5 tokens each, restarting at 0.
      run_limit();
      en_l = 1'b0;
      repeat (2) @(negedge clk);
      check("l_done_clear", 32'(done_l), 32'd0);
      run_limit();
      en_l = 1'b0;
      repeat (2) @(negedge clk);

      // Stall: slow consumer, req/data must hold.
      ack_dly = 20;
      mode_a  = 2'd0;
      q_a.push_back(16'd0);
      en_a = 1'b1;
      wait_empty_a(100);
      r    = if_a.req;
      d    = if_a.data;
      held = 1'b1;
      repeat (18) begin
         @(negedge clk);
         if (if_a.req != r || if_a.data != d) held = 1'b0;
      end
      check("a_stall_hold", 32'(held), 32'd1);

      // Enable drop while waiting: token completes, then idle and quiet.
      en_a = 1'b0;
      wait_idle_a(100);
      check("a_drop_done", 32'(done_a), 32'd0);
      check("a_drop_stepped", 32'(if_a.data), 32'd2);
      check("a_drop_ack_match", 32'(if_a.ack), 32'(if_a.req));
      r    = if_a.req;
      held = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (if_a.req != r || busy_a) held = 1'b0;
      end
      check("a_drop_quiet", 32'(held), 32'd1);

      // Reset while waiting on the third token.
      q_a.push_back(16'd0); q_a.push_back(16'd2); q_a.push_back(16'd6);
      en_a = 1'b1;
      wait_empty_a(300);
      repeat (2) @(negedge clk);
      check("a_pre_rst_req", 32'(if_a.req), FourPh ? 32'd1 : 32'(ev_a % 2));
      check("a_pre_rst_busy", 32'(busy_a), 32'd1);
      rst  = 1'b1;
      en_a = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("a_rst_req", 32'(if_a.req), 32'd0);
      check("a_rst_data", 32'(if_a.data), 32'd0);
      check("a_rst_busy", 32'(busy_a), 32'd0);
      check("a_rst_done", 32'(done_a), 32'd0);
      held = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (if_a.req != 1'b0 || busy_a) held = 1'b0;
      end
      check("a_rst_quiet", 32'(held), 32'd0 + 32'(1'b1));

      // Handshake ordering for a single token after reset.
      ack_dly = 0;
      mode_a  = 2'd0;
      q_a.push_back(16'd0);
      en_a = 1'b1;
`ifdef TOKENFLOW_FOUR_PHASE_EN
      for (int i = 0; i < 50 && !if_a.req; i++) @(negedge clk);
      check("ord_req_up", 32'(if_a.req), 32'd1);
      check("ord_ack_low_at_req_up", 32'(if_a.ack), 32'd0);
      en_a = 1'b0;
      for (int i = 0; i < 50 && !if_a.ack; i++) @(negedge clk);
      check("ord_ack_up", 32'(if_a.ack), 32'd1);
      check("ord_req_high_at_ack_up", 32'(if_a.req), 32'd1);
      for (int i = 0; i < 50 && if_a.req; i++) @(negedge clk);
      check("ord_req_down", 32'(if_a.req), 32'd0);
      check("ord_ack_high_at_req_down", 32'(if_a.ack), 32'd1);
      for (int i = 0; i < 50 && if_a.ack; i++) @(negedge clk);
      check("ord_ack_down", 32'(if_a.ack), 32'd0);
      check("ord_req_low_at_ack_down", 32'(if_a.req), 32'd0);
`else
      for (int i = 0; i < 50 && if_a.req == if_a.ack; i++) @(negedge clk);
      check("ord_req_toggle", 32'(if_a.req), 32'd1);
      check("ord_ack_behind", 32'(if_a.ack), 32'd0);
      en_a = 1'b0;
      for (int i = 0; i < 50 && if_a.req != if_a.ack; i++) @(negedge clk);
      check("ord_ack_follow", 32'(if_a.ack), 32'd1);
      check("ord_req_held", 32'(if_a.req), 32'd1);
`endif
      wait_idle_a(100);
      check("ord_step_value", 32'(if_a.data), 32'd2);

      repeat (5) @(negedge clk);
      check("end_q_a", 32'(q_a.size()), 32'd0);
      check("end_q_w", 32'(q_w.size()), 32'd0);
      check("end_q_l", 32'(q_l.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
